instruction_queue_param: RTL and testbench

- Parametrised successor of the 32-entry in-order instruction queue. It sits between fetch/decode and the ROB/RS/LSB dispatch targets.
- Buffers decoded instructions with PC, op type and branch prediction bit.
- Dispatches at most one instruction per cycle at full throughput, instead of one per two cycles.
- Occupancy-counted, so all DEPTH slots are usable. Adds almost-full back-pressure and a sticky overflow error.

---
 rtl/instruction_queue_param.sv | 136 +++++++++++++
 tb/tb_instruction_queue_param.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue_param.sv
// Parametrised in-order instruction queue between decode and ROB/RS/LSB dispatch.
// Optional stall-cycle counter enabled by defining ISQ_STALL_CNT_EN.

`ifndef ILoadType
`define ILoadType 3'b010
`endif
`ifndef SType
`define SType 3'b011
`endif

module instruction_queue_param #(
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int AF_MARGIN = 2,
  parameter int XLEN      = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              roll_back,
  input  logic              instruction_ready,
  input  logic [XLEN-1:0]   instruction_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              pc_predict_in,
  input  logic [2:0]        op_type_in,
  input  logic              rob_is_full,
  input  logic              rs_is_full,
  input  logic              lsb_is_full,
  output logic              ins_to_rob,
  output logic              ins_to_rs,
  output logic              ins_to_lsb,
  output logic [XLEN-1:0]   instruction_out,
  output logic [XLEN-1:0]   ins_pc_out,
  output logic              pc_predict_out,
  output logic [ADDR_W:0]   count_out,
  output logic              is_full,
  output logic              almost_full,
  output logic              overflow_err
`ifdef ISQ_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_CNT    = (ADDR_W+1)'(AF_MARGIN);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [XLEN-1:0]   ins_mem  [DEPTH];
  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic              pred_mem [DEPTH];
  logic [2:0]        op_mem   [DEPTH];

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] rear;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   free_slots;
  logic              head_to_lsb;
  logic              do_enq;
  logic              do_deq;

  assign count_out   = count;
  assign is_full     = (count == DEPTH_CNT);
  assign free_slots  = DEPTH_CNT - count;
  assign almost_full = (free_slots <= AF_CNT);

  // Memory ops (loads and stores) go to the LSB, everything else to the RS.
  assign head_to_lsb = (op_mem[head] == `SType) || (op_mem[head] == `ILoadType);
  assign do_enq      = instruction_ready && !is_full;
  assign do_deq      = (count != '0) && !rob_is_full &&
                       (head_to_lsb ? !lsb_is_full : !rs_is_full);

  always_ff @(posedge clk_in) begin
    if (!rst_in && !roll_back && rdy_in && do_enq) begin
      ins_mem[rear]  <= instruction_in;
      pc_mem[rear]   <= pc_in;
      pred_mem[rear] <= pc_predict_in;
      op_mem[rear]   <= op_type_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head            <= '0;
      rear            <= '0;
      count           <= '0;
      ins_to_rob      <= 1'b0;
      ins_to_rs       <= 1'b0;
      ins_to_lsb      <= 1'b0;
      instruction_out <= '0;
      ins_pc_out      <= '0;
      pc_predict_out  <= 1'b0;
      overflow_err    <= 1'b0;
    end else if (roll_back) begin
      // Flush pointers and pulses; data outputs and the error flag survive.
      head       <= '0;
      rear       <= '0;
      count      <= '0;
      ins_to_rob <= 1'b0;
      ins_to_rs  <= 1'b0;
      ins_to_lsb <= 1'b0;
    end else if (rdy_in) begin
      if (do_enq)
        rear <= rear + PTR_ONE;
      if (instruction_ready && is_full)
        overflow_err <= 1'b1;
      ins_to_rob <= do_deq;
      ins_to_rs  <= do_deq && !head_to_lsb;
      ins_to_lsb <= do_deq && head_to_lsb;
      if (do_deq) begin
        instruction_out <= ins_mem[head];
        ins_pc_out      <= pc_mem[head];
        pc_predict_out  <= pred_mem[head];
        head            <= head + PTR_ONE;
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef ISQ_STALL_CNT_EN
  // Counts cycles where work is waiting but nothing could dispatch.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      stall_cycles <= '0;
    else if (rdy_in && !roll_back && (count != '0) && !do_deq &&
             (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instruction_queue_param.sv
// Directed self-checking bench for instruction_queue_param (DEPTH=32 default build).

module tb_instruction_queue_param;

  localparam logic [2:0] OP_ALU   = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b011;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic        instruction_ready;
  logic [31:0] instruction_in;
  logic [31:0] pc_in;
  logic        pc_predict_in;
  logic [2:0]  op_type_in;
  logic        rob_is_full;
  logic        rs_is_full;
  logic        lsb_is_full;
  logic        ins_to_rob;
  logic        ins_to_rs;
  logic        ins_to_lsb;
  logic [31:0] instruction_out;
  logic [31:0] ins_pc_out;
  logic        pc_predict_out;
  logic [5:0]  count_out;
  logic        is_full;
  logic        almost_full;
  logic        overflow_err;
`ifdef ISQ_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks;
  int errors;

  instruction_queue_param dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .roll_back         (roll_back),
    .instruction_ready (instruction_ready),
    .instruction_in    (instruction_in),
    .pc_in             (pc_in),
    .pc_predict_in     (pc_predict_in),
    .op_type_in        (op_type_in),
    .rob_is_full       (rob_is_full),
    .rs_is_full        (rs_is_full),
    .lsb_is_full       (lsb_is_full),
    .ins_to_rob        (ins_to_rob),
    .ins_to_rs         (ins_to_rs),
    .ins_to_lsb        (ins_to_lsb),
    .instruction_out   (instruction_out),
    .ins_pc_out        (ins_pc_out),
    .pc_predict_out    (pc_predict_out),
    .count_out         (count_out),
    .is_full           (is_full),
    .almost_full       (almost_full),
    .overflow_err      (overflow_err)
`ifdef ISQ_STALL_CNT_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_ins(input logic [2:0] op, input logic [31:0] pc);
    instruction_ready = 1'b1;
    op_type_in        = op;
    pc_in             = pc;
    instruction_in    = 32'h1300_0000 | pc;
    pc_predict_in     = pc[2];
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    set_ins(OP_ALU, 32'h0000_0040);
    step();
    step();
    rst_in = 1'b0;
    instruction_ready = 1'b0;
    checks++; if (count_out !== 6'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count_out); end
    checks++; if ({ins_to_rob, ins_to_rs, ins_to_lsb} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses got %b want 000", {ins_to_rob, ins_to_rs, ins_to_lsb}); end
    checks++; if (ins_pc_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h want 0", ins_pc_out); end
    checks++; if (instruction_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_ins got %h want 0", instruction_out); end
    checks++; if ({is_full, almost_full, overflow_err, pc_predict_out} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags got %b want 0000", {is_full, almost_full, overflow_err, pc_predict_out}); end
    step();
    checks++; if (count_out !== 6'd0) begin errors++; $display("[TB] FAIL reset_idle_count got %0d want 0", count_out); end
  endtask

  task automatic test_alu_stream();
    for (int i = 0; i < 4; i++) begin
      set_ins(OP_ALU, 32'(4 * i));
      step();
      if (i == 0) begin
        checks++; if (ins_to_rob !== 1'b0) begin errors++; $display("[TB] FAIL alu_first_latency got rob=%b want 0", ins_to_rob); end
      end else begin
        checks++; if ({ins_to_rob, ins_to_rs, ins_to_lsb} !== 3'b110) begin errors++; $display("[TB] FAIL alu_pulse%0d got %b want 110", i, {ins_to_rob, ins_to_rs, ins_to_lsb}); end
        checks++; if (ins_pc_out !== 32'(4 * (i - 1))) begin errors++; $display("[TB] FAIL alu_pc%0d got %h want %h", i, ins_pc_out, 32'(4 * (i - 1))); end
        checks++; if (instruction_out !== (32'h1300_0000 | 32'(4 * (i - 1)))) begin errors++; $display("[TB] FAIL alu_ins%0d got %h", i, instruction_out); end
      end
      checks++; if (count_out !== 6'd1) begin errors++; $display("[TB] FAIL alu_count%0d got %0d want 1", i, count_out); end
    end
    instruction_ready = 1'b0;
    step();
    checks++; if ({ins_to_rob, ins_to_rs, ins_to_lsb} !== 3'b110) begin errors++; $display("[TB] FAIL alu_last_pulse got %b want 110", {ins_to_rob, ins_to_rs, ins_to_lsb}); end
    checks++; if (ins_pc_out !== 32'hC) begin errors++; $display("[TB] FAIL alu_last_pc got %h want c", ins_pc_out); end
    checks++; if (pc_predict_out !== 1'b1) begin errors++; $display("[TB] FAIL alu_pred got %b want 1", pc_predict_out); end
    checks++; if (count_out !== 6'd0) begin errors++; $display("[TB] FAIL alu_drain_count got %0d want 0", count_out); end
    step();
    checks++; if ({ins_to_rob, ins_to_rs, ins_to_lsb} !== 3'b000) begin errors++; $display("[TB] FAIL alu_idle_pulse got %b want 000", {ins_to_rob, ins_to_rs, ins_to_lsb}); end
    checks++; if (ins_pc_out !== 32'hC) begin errors++; $display("[TB] FAIL alu_hold_pc got %h want c", ins_pc_out); end
  endtask

  task automatic test_store_lsb_full();
    lsb_is_full = 1'b1;
    set_ins(OP_STORE, 32'h100);
    step();
    instruction_ready = 1'b0;
    checks++; if (count_out !== 6'd1) begin errors++; $display("[TB] FAIL st_count got %0d want 1", count_out); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if ({ins_to_rob, ins_to_rs, ins_to_lsb} !== 3'b000) begin errors++; $display("[TB] FAIL st_blocked%0d got %b want 000", k, {ins_to_rob, ins_to_rs, ins_to_lsb}); end
    end
    lsb_is_full = 1'b0;
    rs_is_full  = 1'b1;
    step();
    checks++; if ({ins_to_rob, ins_to_rs, ins_to_lsb} !== 3'b101) begin errors++; $display("[TB] FAIL st_pulse got %b want 101", {ins_to_rob, ins_to_rs, ins_to_lsb}); end
    checks++; if (ins_pc_out !== 32'h100) begin errors++; $display("[TB] FAIL st_pc got %h want 100", ins_pc_out); end
    checks++; if (count_out !== 6'd0) begin errors++; $display("[TB] FAIL st_drain got %0d want 0", count_out); end
    step();
    checks++; if ({ins_to_rob, ins_to_rs, ins_to_lsb} !== 3'b000) begin errors++; $display("[TB] FAIL st_single got %b want 000", {ins_to_rob, ins_to_rs, ins_to_lsb}); end
    rs_is_full = 1'b0;
  endtask

  task automatic test_fill_overflow();
    rob_is_full = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_ins(OP_ALU, 32'h200 + 32'(4 * i));
      step();
      checks++; if (count_out !== 6'(i + 1)) begin errors++; $display("[TB] FAIL fill_count%0d got %0d want %0d", i, count_out, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 30)) begin errors++; $display("[TB] FAIL fill_af%0d got %b", i, almost_full); end
      checks++; if (is_full !== (i + 1 == 32)) begin errors++; $display("[TB] FAIL fill_full%0d got %b", i, is_full); end
    end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_ovf got %b want 0", overflow_err); end
    set_ins(OP_ALU, 32'h999);
    step();
    instruction_ready = 1'b0;
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b want 1", overflow_err); end
    checks++; if (count_out !== 6'd32) begin errors++; $display("[TB] FAIL ovf_count got %0d want 32", count_out); end
    roll_back = 1'b1;
    step();
    roll_back = 1'b0;
    checks++; if (count_out !== 6'd0) begin errors++; $display("[TB] FAIL rb_full_count got %0d want 0", count_out); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL rb_keeps_ovf got %b want 1", overflow_err); end
    checks++; if (ins_pc_out !== 32'h100) begin errors++; $display("[TB] FAIL rb_hold_pc got %h want 100", ins_pc_out); end
    rob_is_full = 1'b0;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got %b want 0", overflow_err); end
  endtask

  task automatic test_back_to_back_wrap();
    rob_is_full = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_ins(OP_ALU, 32'h1000 + 32'(4 * i));
      step();
    end
    instruction_ready = 1'b0;
    checks++; if (count_out !== 6'd32) begin errors++; $display("[TB] FAIL wrap_fill got %0d want 32", count_out); end
    rob_is_full = 1'b0;
    step();
    checks++; if (ins_pc_out !== 32'h1000) begin errors++; $display("[TB] FAIL wrap_first got %h want 1000", ins_pc_out); end
    checks++; if (count_out !== 6'd31) begin errors++; $display("[TB] FAIL wrap_first_count got %0d want 31", count_out); end
    for (int k = 0; k < 40; k++) begin
      set_ins(OP_ALU, 32'h1000 + 32'(4 * (32 + k)));
      step();
      checks++; if (ins_pc_out !== 32'h1000 + 32'(4 * (k + 1)) || ins_to_rob !== 1'b1 || ins_to_rs !== 1'b1) begin errors++; $display("[TB] FAIL wrap_steady%0d got pc=%h rob=%b rs=%b want pc=%h", k, ins_pc_out, ins_to_rob, ins_to_rs, 32'h1000 + 32'(4 * (k + 1))); end
      checks++; if (count_out !== 6'd31) begin errors++; $display("[TB] FAIL wrap_count%0d got %0d want 31", k, count_out); end
    end
    instruction_ready = 1'b0;
    for (int k = 0; k < 31; k++) begin
      step();
      checks++; if (ins_pc_out !== 32'h1000 + 32'(4 * (41 + k)) || ins_to_rob !== 1'b1) begin errors++; $display("[TB] FAIL wrap_drain%0d got pc=%h rob=%b want pc=%h", k, ins_pc_out, ins_to_rob, 32'h1000 + 32'(4 * (41 + k))); end
    end
    checks++; if (count_out !== 6'd0) begin errors++; $display("[TB] FAIL wrap_empty got %0d want 0", count_out); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL wrap_ovf got %b want 0", overflow_err); end
    step();
    checks++; if (ins_to_rob !== 1'b0) begin errors++; $display("[TB] FAIL wrap_idle got %b want 0", ins_to_rob); end
  endtask

  task automatic test_roll_back();
    rob_is_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_ins(OP_ALU, 32'h2000 + 32'(4 * i));
      step();
    end
    checks++; if (count_out !== 6'd10) begin errors++; $display("[TB] FAIL rb_pre_count got %0d want 10", count_out); end
    set_ins(OP_ALU, 32'h2FFC);
    roll_back   = 1'b1;
    rob_is_full = 1'b0;
    step();
    roll_back = 1'b0;
    instruction_ready = 1'b0;
    checks++; if (count_out !== 6'd0) begin errors++; $display("[TB] FAIL rb_count got %0d want 0", count_out); end
    checks++; if ({ins_to_rob, ins_to_rs, ins_to_lsb} !== 3'b000) begin errors++; $display("[TB] FAIL rb_pulses got %b want 000", {ins_to_rob, ins_to_rs, ins_to_lsb}); end
    checks++; if (ins_pc_out !== 32'h111C) begin errors++; $display("[TB] FAIL rb_hold got %h want 111c", ins_pc_out); end
    step();
    checks++; if (count_out !== 6'd0 || ins_to_rob !== 1'b0) begin errors++; $display("[TB] FAIL rb_not_stored got count=%0d rob=%b want 0/0", count_out, ins_to_rob); end
    set_ins(OP_ALU, 32'h2100);
    step();
    instruction_ready = 1'b0;
    step();
    checks++; if (ins_pc_out !== 32'h2100 || ins_to_rob !== 1'b1) begin errors++; $display("[TB] FAIL rb_restart got pc=%h rob=%b want 2100/1", ins_pc_out, ins_to_rob); end
  endtask

  task automatic test_pause();
    rob_is_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_ins(OP_ALU, 32'h3000 + 32'(4 * i));
      step();
    end
    instruction_ready = 1'b0;
    rob_is_full = 1'b0;
    step();
    checks++; if (ins_pc_out !== 32'h3000 || ins_to_rob !== 1'b1) begin errors++; $display("[TB] FAIL pause_first got pc=%h rob=%b want 3000/1", ins_pc_out, ins_to_rob); end
    rdy_in = 1'b0;
    set_ins(OP_ALU, 32'h3FFC);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (ins_to_rob !== 1'b1 || ins_to_rs !== 1'b1 || ins_pc_out !== 32'h3000) begin errors++; $display("[TB] FAIL pause_hold%0d got rob=%b rs=%b pc=%h want 1/1/3000", k, ins_to_rob, ins_to_rs, ins_pc_out); end
      checks++; if (count_out !== 6'd5) begin errors++; $display("[TB] FAIL pause_count%0d got %0d want 5", k, count_out); end
    end
    rdy_in = 1'b1;
    instruction_ready = 1'b0;
    for (int j = 1; j < 6; j++) begin
      step();
      checks++; if (ins_pc_out !== 32'h3000 + 32'(4 * j) || ins_to_rob !== 1'b1) begin errors++; $display("[TB] FAIL pause_resume%0d got pc=%h rob=%b want %h", j, ins_pc_out, ins_to_rob, 32'h3000 + 32'(4 * j)); end
      checks++; if (count_out !== 6'(5 - j)) begin errors++; $display("[TB] FAIL pause_rcount%0d got %0d want %0d", j, count_out, 5 - j); end
    end
    step();
    checks++; if (ins_to_rob !== 1'b0 || count_out !== 6'd0) begin errors++; $display("[TB] FAIL pause_end got rob=%b count=%0d want 0/0", ins_to_rob, count_out); end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_in            = 1'b0;
    rdy_in            = 1'b1;
    roll_back         = 1'b0;
    instruction_ready = 1'b0;
    instruction_in    = '0;
    pc_in             = '0;
    pc_predict_in     = 1'b0;
    op_type_in        = OP_ALU;
    rob_is_full       = 1'b0;
    rs_is_full        = 1'b0;
    lsb_is_full       = 1'b0;
    test_reset();
    test_alu_stream();
    test_store_lsb_full();
    test_fill_overflow();
    test_back_to_back_wrap();
    test_roll_back();
    test_pause();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
